// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: shared prescaler and period counter, per-channel
// enables and double-buffered duty registers, global output invert.
module pwm_multi_channel #(
    parameter int NUM_CH = 16,
    parameter int RES    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              wr_en,
    input  logic [7:0]        wr_addr,
    input  logic [7:0]        wr_data,
    output logic [NUM_CH-1:0] out,
    output logic              period_start
);

    localparam logic [RES-1:0] CNT_MAX    = {RES{1'b1}};
    localparam logic [7:0]     ADDR_PRESC = 8'h08;
    localparam logic [7:0]     ADDR_MODE  = 8'h09;

    logic [7:0]        r_pcnt;
    logic [7:0]        r_presc;
    logic              r_mode;
    logic [RES-1:0]    r_cnt;
    logic [NUM_CH-1:0] r_out;
    logic              r_period_start;

    logic              w_tick;
    logic              w_wrap;
    logic [NUM_CH-1:0] w_level;

    // Greater-or-equal so that lowering the prescale value never strands pcnt above it.
    assign w_tick = ena && (r_pcnt >= r_presc);
    assign w_wrap = w_tick && (r_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt <= '0;
            r_cnt  <= '0;
        end else if (ena) begin
            if (w_tick) begin
                r_pcnt <= '0;
                r_cnt  <= r_cnt + 1'b1;
            end else begin
                r_pcnt <= r_pcnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_mode  <= 1'b0;
        end else if (wr_en) begin
            if (wr_addr == ADDR_PRESC) r_presc <= wr_data;
            if (wr_addr == ADDR_MODE)  r_mode  <= wr_data[0];
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [7:0] EN_ADDR   = 8'(gi / 8);
            localparam logic [7:0] PWM_ADDR  = 8'(4 + gi / 8);
            localparam logic [7:0] DUTY_ADDR = 8'(32 + gi);
            localparam int         BIT       = gi % 8;

            logic           r_en_out;
            logic           r_en_pwm;
            logic [RES-1:0] r_duty_shadow;
            logic [RES-1:0] r_duty_act;
            logic           w_raw;

            // duty_act samples the pre-edge shadow, so a write on the wrap edge waits a period.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_en_out      <= 1'b0;
                    r_en_pwm      <= 1'b0;
                    r_duty_shadow <= '0;
                    r_duty_act    <= '0;
                end else begin
                    if (wr_en && (wr_addr == EN_ADDR))   r_en_out      <= wr_data[BIT];
                    if (wr_en && (wr_addr == PWM_ADDR))  r_en_pwm      <= wr_data[BIT];
                    if (wr_en && (wr_addr == DUTY_ADDR)) r_duty_shadow <= wr_data[RES-1:0];
                    if (w_wrap)                          r_duty_act    <= r_duty_shadow;
                end
            end

            always_comb begin
                w_raw = 1'b0;
                if (r_en_out) begin
                    if (!r_en_pwm || (r_duty_act == CNT_MAX)) w_raw = 1'b1;
                    else                                      w_raw = (r_cnt < r_duty_act);
                end
            end

            assign w_level[gi] = w_raw ^ r_mode;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_out          <= w_level;
            r_period_start <= w_wrap;
        end
    end

    assign out          = r_out;
    assign period_start = r_period_start;

endmodule

// File: doc/pwm_multi_channel.md
# pwm_multi_channel

Parametrised multi-channel PWM generator with per-channel duty cycles, a programmable prescaler, double-buffered duty updates and a global output-invert mode. It sits behind the SPI register peripheral in the chip top and is fed by its byte-write strobe. Its channel outputs drive uo_out/uio_out. It replaces the single shared-duty PWM block.

## Interface

Parameters:
- NUM_CH, default 16: number of channels, legal range 1..32.
- RES, default 8: counter and duty width in bits, legal range 1..8.

Ports:
- clk  input  1  system clock; everything is synchronous to its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  count enable; when low, the prescaler and counter freeze.
- wr_en  input  1  one-cycle register write strobe.
- wr_addr  input  8  register address.
- wr_data  input  8  register write data.
- out  output  NUM_CH  registered PWM outputs.
- period_start  output  1  one-cycle pulse at each period boundary.

## Operation

Register map. Writes to unmapped addresses are ignored. Bits belonging to channels at or above NUM_CH are ignored.
- 0x00–0x03 en_out: byte k holds channels 8k..8k+7. Takes effect immediately.
- 0x04–0x07 en_pwm: same layout as en_out. Takes effect immediately.
- 0x08 prescale P (8 bits).
- 0x09 mode: bit0 = invert all outputs; other bits are ignored.
- 0x20+ch duty_shadow[ch] ← wr_data[RES-1:0], for ch < NUM_CH only.

Prescaler:
- pcnt is 8 bits.
- On each ena cycle: if pcnt ≥ P, then tick = 1 and pcnt ← 0; otherwise pcnt ← pcnt+1.
- The ≥ compare means lowering P never stalls the prescaler.

Counter:
- cnt is RES bits and increments on tick.
- It wraps from 2^RES−1 to 0.
- The wrap edge is the period boundary.

Double buffering:
- On the boundary edge, duty_act[ch] ← duty_shadow[ch] for all channels simultaneously.
- If a shadow write lands on the boundary cycle, the pre-write shadow value is loaded; the new value takes effect at the following boundary.

Per-channel level, computed combinationally and then registered into out:
- en_out = 0 → 0.
- en_out = 1, en_pwm = 0 → 1 (static high).
- en_out = 1, en_pwm = 1, duty_act = 2^RES−1 → 1 (always high).
- en_out = 1, en_pwm = 1, otherwise → (cnt < duty_act). duty_act = 0 therefore gives constant low.
- The result is XORed with mode.bit0. Inversion also applies to disabled channels, so they read 1 when invert is set.

Period: (P+1)·2^RES clk cycles of ena=1. High time: duty·(P+1) cycles.

## Timing

Reset (async assert, sync-safe release):
- pcnt, cnt, duty_shadow, duty_act, en_out, en_pwm, P and mode all clear to 0.
- out = 0 and period_start = 0 while rst_n is low and on the first cycle after release.
- Reset mid-period aborts immediately; counting restarts from cnt = 0 with all channels disabled.

Latency:
- Register write on edge N → register updated at N; out reflects it at edge N+1.
- out lags cnt by one cycle (registered output).
- period_start is high for exactly one cycle, following the edge at which cnt wraps to 0. It is also the first cycle in which duty_act holds the new values, one cycle before out shows the new period.
- period_start is not asserted after reset until the first wrap.

ena = 0:
- pcnt, cnt and duty_act hold.
- out holds its last value, apart from changes due to en/mode writes.
- Register writes are still accepted; period_start stays 0.

Writing P:
- The new value is used from the next cycle.
- pcnt is not reset.

## Test plan

- NUM_CH=16, RES=8, P=0. Write en_out[0]=1, en_pwm[0]=1, duty0=0x80, then run two periods → from the second period, out[0] is high for 128 of every 256 cycles and period_start pulses every 256 cycles.
- Double buffer. With duty0=0x80 running, write duty0=0x40 at cnt=0x10 → the current period still gives 128 high cycles; the next period gives 64. A write landing on the boundary cycle is applied one period later.
- Edge duties. duty=0xFF → out constantly 1. duty=0x00 → constantly 0. en_pwm=0 with en_out=1 → constant 1. en_out=0 → constant 0 regardless of duty.
- Prescaler. P=3, duty=0x40 → period of 1024 cycles with 256 high. Change P to 0 mid-period with pcnt=2 → ticks resume the next cycle with no stall.
- Invert and channel mapping. mode=1 → every out bit is complemented, including disabled channels. Write en_out byte 0x01=0xFF → channels 8–15 are enabled. With NUM_CH=12, upper bits and duty addresses 0x2C+ are ignored.
- ena/reset. Drop ena for 50 cycles mid-period → out, cnt and the period phase are frozen and resume exactly. Assert rst_n low mid-period → out=0 and period_start=0 immediately, and all registers read back as their zero-effect state.
